// File: rtl/branch_lut_pkg.sv
// Purpose: shared types and constants for the branch target-table loader.
// Latency: n/a (types only).
// Backpressure: n/a. Optional feature macro: BRANCH_LUT_LOADER_CHECKSUM_EN adds the CHK state.
package branch_lut_pkg;

  // Write-index width; with ADDR_W = 4, up to 16 table entries can be addressed.
  localparam int ADDR_W          = 4;
  localparam int NUM_ENTRIES_DEF = 16;

`ifdef BRANCH_LUT_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_DONE = 3'd4
  } state_t;
`endif

endpackage

// File: rtl/branch_lut_loader.sv
// Purpose: assembles a byte stream (low byte, then high byte) into D-bit branch targets and
//   writes NUM_ENTRIES of them into the target table at indices 0..NUM_ENTRIES-1.
// Latency: wr_en/wr_addr/wr_data appear 1 cycle after the high byte is accepted.
// Backpressure: in_ready is high only while loading (LO/HI/CHK); bytes are ignored in IDLE/DONE.
// Ports: clk, reset (async, active-high), start (restart pulse), in_valid/in_data/in_ready
//   (byte stream), wr_en/wr_addr/wr_data (table write port), busy, done, count,
//   chk_err (only with BRANCH_LUT_LOADER_CHECKSUM_EN defined).
module branch_lut_loader
  import branch_lut_pkg::*;
#(
  parameter int D           = 10,
  parameter int NUM_ENTRIES = NUM_ENTRIES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [D-1:0]      wr_data,
  output logic              busy,
  output logic              done,
`ifdef BRANCH_LUT_LOADER_CHECKSUM_EN
  output logic              chk_err,
`endif
  output logic [4:0]        count
);

  state_t              state_q, state_d;
  logic [7:0]          lo_q, lo_d;
  logic [4:0]          count_q, count_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [D-1:0]        wr_data_q, wr_data_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept;
`ifdef BRANCH_LUT_LOADER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
  logic                chk_err_q, chk_err_d;
`endif

  // in_ready_q is the registered image of "state is LO/HI/CHK".
  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef BRANCH_LUT_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
    chk_err_d = chk_err_q;
`endif
    if (start) begin
      // Restart wins over any byte presented in the same cycle.
      state_d = ST_LO;
      lo_d    = 8'd0;
      count_d = 5'd0;
`ifdef BRANCH_LUT_LOADER_CHECKSUM_EN
      sum_d     = 8'd0;
      chk_err_d = 1'b0;
`endif
    end else if (accept) begin
      case (state_q)
        ST_LO: begin
          lo_d    = in_data;
          state_d = ST_HI;
`ifdef BRANCH_LUT_LOADER_CHECKSUM_EN
          sum_d   = sum_q + in_data;
`endif
        end
        ST_HI: begin
          wr_en_d   = 1'b1;
          wr_addr_d = count_q[ADDR_W-1:0];
          // Only the low D-8 bits of the high byte belong to the target.
          wr_data_d = {in_data[D-9:0], lo_q};
          count_d   = count_q + 5'd1;
`ifdef BRANCH_LUT_LOADER_CHECKSUM_EN
          sum_d     = sum_q + in_data;
`endif
          if (count_q == 5'(NUM_ENTRIES - 1)) begin
`ifdef BRANCH_LUT_LOADER_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_LO;
          end
        end
`ifdef BRANCH_LUT_LOADER_CHECKSUM_EN
        ST_CHK: begin
          chk_err_d = (in_data != sum_q);
          state_d   = ST_DONE;
        end
`endif
        default: state_d = state_q;
      endcase
    end
    // Status outputs are registered from the next state so they line up with state_q.
    in_ready_d = (state_d == ST_LO) || (state_d == ST_HI)
`ifdef BRANCH_LUT_LOADER_CHECKSUM_EN
                 || (state_d == ST_CHK)
`endif
                 ;
    busy_d = in_ready_d;
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lo_q       <= 8'd0;
      count_q    <= 5'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef BRANCH_LUT_LOADER_CHECKSUM_EN
      sum_q      <= 8'd0;
      chk_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      count_q    <= count_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef BRANCH_LUT_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
      chk_err_q  <= chk_err_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
`ifdef BRANCH_LUT_LOADER_CHECKSUM_EN
  assign chk_err  = chk_err_q;
`endif

endmodule

// File: tb/tb_branch_lut_loader.sv
// Purpose: self-checking bench for branch_lut_loader (directed table, corner sequences, random).
// Latency: n/a.
// Backpressure: n/a. Build with BRANCH_LUT_LOADER_CHECKSUM_EN defined to exercise chk_err.
module tb_branch_lut_loader;
  import branch_lut_pkg::*;

  localparam int D = 10;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready, wr_en, busy, done;
  logic [3:0]  wr_addr;
  logic [D-1:0] wr_data;
  logic [4:0]  count;
`ifdef BRANCH_LUT_LOADER_CHECKSUM_EN
  logic        chk_err;
`endif

  branch_lut_loader #(.D(D), .NUM_ENTRIES(N)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done),
`ifdef BRANCH_LUT_LOADER_CHECKSUM_EN
    .chk_err(chk_err),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: tracks bytes taken since start; entries are byte pairs.
  bit m_active = 0, m_done = 0, m_wr = 0, m_err = 0;
  int m_nb = 0, m_count = 0, m_lo = 0, m_sum = 0, m_addr = 0, m_data = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_wr = 0; m_err = 0;
    m_nb = 0; m_count = 0; m_lo = 0; m_sum = 0;
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".wr_en"},    int'(wr_en),    int'(m_wr));
    if (m_wr) begin
      chk({tag, ".wr_addr"}, int'(wr_addr), m_addr);
      chk({tag, ".wr_data"}, int'(wr_data), m_data);
    end
    chk({tag, ".count"},    int'(count),    m_count);
    chk({tag, ".busy"},     int'(busy),     int'(m_active));
    chk({tag, ".in_ready"}, int'(in_ready), int'(m_active));
    chk({tag, ".done"},     int'(done),     int'(m_done));
`ifdef BRANCH_LUT_LOADER_CHECKSUM_EN
    chk({tag, ".chk_err"},  int'(chk_err),  int'(m_err));
`endif
  endtask

  // Drive one cycle (called at posedge+1), update the model, compare at next posedge+1.
  task automatic step(input logic s, input logic v, input logic [7:0] d, input string tag);
    start = s; in_valid = v; in_data = d;
    m_wr = 0;
    if (s) begin
      m_active = 1; m_nb = 0; m_count = 0; m_done = 0; m_sum = 0; m_err = 0; m_lo = 0;
    end else if (m_active && v) begin
      if (m_nb < 2 * N) begin
        if (m_nb % 2 == 0) m_lo = int'(d);
        else begin
          m_wr = 1;
          m_addr = m_nb / 2;
          m_data = ((int'(d) % (1 << (D - 8))) * 256) + m_lo;
          m_count++;
        end
        m_sum = (m_sum + int'(d)) % 256;
        m_nb++;
`ifndef BRANCH_LUT_LOADER_CHECKSUM_EN
        if (m_nb == 2 * N) begin m_active = 0; m_done = 1; end
`endif
      end else begin
        m_err = (int'(d) != m_sum);
        m_active = 0; m_done = 1;
      end
    end
    @(posedge clk); #1;
    compare_model(tag);
  endtask

  typedef struct {
    logic s; logic v; logic [7:0] d;
    logic e_wr; int e_addr; int e_data; int e_count; logic e_busy; logic e_done;
  } vec_t;
  vec_t tbl[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, exp_addr, lsum;
    logic [7:0] b;

    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 0,     0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'h2C, 1'b0, 0, 0,     0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'hFF, 1'b1, 0, 'h32C, 1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 8'h05, 1'b0, 0, 0,     1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1, 'h205, 2, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 8'hAA, 1'b0, 0, 0,     2, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'h10, 1'b0, 0, 0,     2, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 8'h01, 1'b1, 2, 'h110, 3, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'h72, 1'b0, 0, 0,     3, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 8'h00, 1'b1, 3, 114,   4, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 0, 0,     4, 1'b1, 1'b0};

    // Reset state (reset held from time 0).
    #23;
    chk("rst.in_ready", int'(in_ready), 0);
    chk("rst.wr_en",    int'(wr_en),    0);
    chk("rst.busy",     int'(busy),     0);
    chk("rst.done",     int'(done),     0);
    chk("rst.wr_addr",  int'(wr_addr),  0);
    chk("rst.wr_data",  int'(wr_data),  0);
    chk("rst.count",    int'(count),    0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Idle ignores bytes.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h99, "idle");

    // Directed table: entries 0..3 including ignored high bits and entry 3 = 114.
    foreach (tbl[i]) begin
      step(tbl[i].s, tbl[i].v, tbl[i].d, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.wr_en", i), int'(wr_en), int'(tbl[i].e_wr));
      if (tbl[i].e_wr) begin
        chk($sformatf("tbl%0d.wr_addr", i), int'(wr_addr), tbl[i].e_addr);
        chk($sformatf("tbl%0d.wr_data", i), int'(wr_data), tbl[i].e_data);
      end
      chk($sformatf("tbl%0d.count", i), int'(count), tbl[i].e_count);
      chk($sformatf("tbl%0d.busy", i),  int'(busy),  int'(tbl[i].e_busy));
      chk($sformatf("tbl%0d.done", i),  int'(done),  int'(tbl[i].e_done));
    end

    // Start on the high byte of entry 5: byte dropped, count cleared, next pair is entry 0.
    step(1'b0, 1'b1, 8'h01, "e4lo");
    step(1'b0, 1'b1, 8'h00, "e4hi");
    step(1'b0, 1'b1, 8'h33, "e5lo");
    step(1'b1, 1'b1, 8'h03, "e5hi_start");
    chk("restart.wr_en", int'(wr_en), 0);
    chk("restart.count", int'(count), 0);
    chk("restart.in_ready", int'(in_ready), 1);
    step(1'b0, 1'b1, 8'h44, "r0lo");
    chk("restart.lo_no_write", int'(wr_en), 0);
    step(1'b0, 1'b1, 8'h01, "r0hi");
    chk("restart.wr_en0", int'(wr_en), 1);
    chk("restart.addr0", int'(wr_addr), 0);
    chk("restart.data0", int'(wr_data), 'h144);
    chk("restart.count1", int'(count), 1);

    // Full load with in_valid toggling every other cycle.
    step(1'b1, 1'b0, 8'h00, "full.start");
    pulses = 0; exp_addr = 0; lsum = 0;
    for (int i = 0; i < 4 * N; i++) begin
      b = 8'($urandom);
      step(1'b0, 1'(i % 2), b, "full");
      if (i % 2 == 1) lsum = (lsum + int'(b)) % 256;
      if (wr_en) begin
        chk("full.addr_order", int'(wr_addr), exp_addr);
        exp_addr++;
        pulses++;
      end
    end
`ifdef BRANCH_LUT_LOADER_CHECKSUM_EN
    chk("full.chk_wait_busy", int'(busy), 1);
    b = 8'(lsum);
    step(1'b0, 1'b1, b, "full.trail");
`endif
    step(1'b0, 1'b0, 8'h00, "full.after");
    chk("full.pulses", pulses, 16);
    chk("full.done", int'(done), 1);
    chk("full.busy", int'(busy), 0);
    chk("full.in_ready", int'(in_ready), 0);
    step(1'b0, 1'b1, 8'h12, "full.ignored");
    chk("full.no_write_in_done", int'(wr_en), 0);

`ifdef BRANCH_LUT_LOADER_CHECKSUM_EN
    // 32 bytes summing to 0x5A, then matching / mismatching trailing byte.
    for (int pass = 0; pass < 2; pass++) begin
      step(1'b1, 1'b0, 8'h00, "ck.start");
      lsum = 0;
      for (int i = 0; i < 2 * N - 1; i++) begin
        step(1'b0, 1'b1, 8'(i), "ck");
        lsum = (lsum + i) % 256;
      end
      b = 8'((8'h5A - lsum) & 8'hFF);
      step(1'b0, 1'b1, b, "ck.last");
      step(1'b0, 1'b1, (pass == 0) ? 8'h5A : 8'h5B, "ck.trail");
      chk("ck.chk_err", int'(chk_err), pass);
      chk("ck.done", int'(done), 1);
    end
`endif

    // Reset between the LO and HI bytes of entry 7.
    step(1'b1, 1'b0, 8'h00, "rm.start");
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 8'(i + 1), "rm.load");
    #2 reset = 1'b1;
    #1;
    chk("rm.in_ready", int'(in_ready), 0);
    chk("rm.wr_en",    int'(wr_en),    0);
    chk("rm.busy",     int'(busy),     0);
    chk("rm.done",     int'(done),     0);
    chk("rm.count",    int'(count),    0);
    chk("rm.wr_addr",  int'(wr_addr),  0);
    chk("rm.wr_data",  int'(wr_data),  0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h77, "rm.idle");
    step(1'b1, 1'b0, 8'h00, "rm.restart");
    step(1'b0, 1'b1, 8'h21, "rm.lo");
    step(1'b0, 1'b1, 8'h03, "rm.hi");
    chk("rm.entry0_addr", int'(wr_addr), 0);

    // Random traffic with occasional restarts.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), 8'($urandom), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_lut_loader.md
BRANCH_LUT_LOADER -- requirements
Module: branch_lut_loader

Interface
REQ-001 SHALL have parameter D, default 10, giving the branch-target width in bits; legal range is 9..16.
REQ-002 SHALL have parameter NUM_ENTRIES, default 16, giving the number of target-table entries to load.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle pulse that begins or restarts a load at entry 0.
REQ-006 SHALL have port in_valid, input, 1 bit: the byte on in_data is valid.
REQ-007 SHALL have port in_data, input, 8 bits: load stream byte.
REQ-008 SHALL have port in_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-009 SHALL have port wr_en, output, 1 bit: target-table write strobe.
REQ-010 SHALL have port wr_addr, output, 4 bits: target-table write index.
REQ-011 SHALL have port wr_data, output, D bits: branch target to write.
REQ-012 SHALL have port busy, output, 1 bit: a load is in progress.
REQ-013 SHALL have port done, output, 1 bit: all NUM_ENTRIES entries have been written.
REQ-014 SHALL have port count, output, 5 bits: number of entries written since the last start.

Function
REQ-015 SHALL implement the states IDLE, LO, HI, CHK (macro builds only) and DONE.
REQ-016 SHALL accept a byte only when in_valid and in_ready are both 1 in the same cycle; in_ready SHALL be 1 exactly in states LO, HI and CHK.
REQ-017 SHALL handle start as follows: from any state, start moves the FSM to LO, clears count, done and any partially assembled entry.
REQ-018 SHALL give start priority over a same-cycle byte transfer; that byte is dropped and no write occurs.
REQ-019 SHALL, in LO, capture in_data as target[7:0] on acceptance and move to HI.
REQ-020 SHALL, in HI, form target[D-1:8] from in_data[D-9:0] on acceptance; in_data[7:D-8] are ignored.
REQ-021 SHALL assert wr_en for exactly one cycle, on the cycle after the HI byte is accepted, with wr_addr = count and wr_data = the assembled target (latency 1).
REQ-022 SHALL increment count in the same cycle that wr_en is asserted.
REQ-023 SHALL go from HI back to LO when the accepted byte completes entry k < NUM_ENTRIES-1, and otherwise to CHK (macro builds) or DONE.
REQ-024 SHALL hold busy = 1 in LO, HI and CHK, and busy = 0 otherwise.
REQ-025 SHALL hold done = 1 in DONE until the next start or reset.
REQ-026 SHALL leave wr_en = 0 in IDLE and DONE, and SHALL ignore in_valid there.
REQ-027 SHALL never advance count past NUM_ENTRIES and SHALL never let wr_addr wrap.

Reset
REQ-028 SHALL, on reset assertion and without waiting for clk, force the FSM to IDLE.
REQ-029 SHALL drive in_ready, wr_en, busy and done to 0 during reset.
REQ-030 SHALL drive wr_addr, wr_data and count to 0 during reset.
REQ-031 SHALL, when reset arrives mid-load, discard the partial entry and issue no further writes.

Configuration
REQ-032 SHALL use the macro BRANCH_LUT_LOADER_CHECKSUM_EN; when it is defined, add output chk_err (1 bit) and the CHK state.
REQ-033 SHALL, with the macro, keep an 8-bit modulo-256 running sum of all 2*NUM_ENTRIES data bytes and accept one trailing byte in CHK.
REQ-034 SHALL, with the macro, move to DONE on that trailing byte and set chk_err = 1 if the byte differs from the running sum; chk_err is cleared by start or reset.
REQ-035 SHALL, without the macro, omit the chk_err port, the CHK state and the sum logic; the last HI byte goes directly to DONE.

Structure
REQ-036 SHALL place the state enum, ADDR_W = 4 and the default NUM_ENTRIES constant in shared package branch_lut_pkg.
REQ-037 SHALL be a single module with no sub-module; its write port connects directly to the writable target table.

Verification
REQ-038 SHALL cover: start, then bytes 0x72,0x00 as entry 3 after entries 0..2 -> wr_en one cycle after the second byte, wr_addr = 3, wr_data = 114, count = 4.
REQ-039 SHALL cover: high byte 0xFF with low byte 0x2C, D = 10 -> wr_data = 0x32C (812); the ignored bits have no effect.
REQ-040 SHALL cover: load all 16 entries with in_valid toggling every other cycle -> exactly 16 wr_en pulses, addresses 0..15 in order, then done = 1, busy = 0, in_ready = 0.
REQ-041 SHALL cover: start asserted in the same cycle as an HI byte of entry 5 -> no write, count = 0, state LO; the next two bytes write entry 0.
REQ-042 SHALL cover: reset asserted between the LO and HI bytes of entry 7 -> all outputs 0 immediately, no further wr_en, and the loader stays IDLE until start.
REQ-043 SHALL cover, in macro builds: 32 bytes summing to 0x5A, then trailing byte 0x5A -> chk_err = 0; trailing byte 0x5B -> chk_err = 1, done = 1.
